// File: rtl/divmmc_pkg.sv
// Shared constants for the divMMC-NG interface: I/O port offsets, automap trap
// addresses, status bit layout and the SPI engine state type.
package divmmc_pkg;

    localparam logic [3:0] PORT_CTRL   = 4'h3;
    localparam logic [3:0] PORT_CARD   = 4'h7;
    localparam logic [3:0] PORT_DATA   = 4'hB;
    localparam logic [3:0] PORT_STATUS = 4'hF;

    localparam int STATUS_BUSY_BIT = 0;

    localparam int NUM_TRAPS = 6;
    localparam logic [15:0] TRAP_ADDRS [NUM_TRAPS] = '{
        16'h0000, 16'h0008, 16'h0038, 16'h0066, 16'h04C6, 16'h0562
    };

    typedef enum logic {
        SPI_IDLE,
        SPI_XFER
    } spi_state_t;

    // Entry points that page divMMC in only once the M1 cycle has completed.
    function automatic logic is_entry_trap(input logic [15:0] addr);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_TRAPS; i++) begin
            if (addr == TRAP_ADDRS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic is_rom_trap(input logic [15:0] addr);
        return addr[15:8] == 8'h3D;
    endfunction

    function automatic logic is_exit_trap(input logic [15:0] addr);
        return addr[15:3] == 13'h03FF;
    endfunction

endpackage

// File: rtl/divmmc_spi_engine.sv
// SPI mode-0 byte shifter: one byte per start strobe, MSB first, each SCK
// phase lasting SPI_DIV clocks; the received byte is latched as busy drops.
module divmmc_spi_engine
    import divmmc_pkg::*;
#(
    parameter int SPI_DIV = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       busy,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    spi_state_t r_state;
    spi_state_t w_state_next;

    logic [7:0] r_div;
    logic [3:0] r_phase;
    logic [7:0] r_tx;
    logic [7:0] r_rx_shift;
    logic [7:0] r_rx;
    logic       r_sck;
    logic       r_mosi;
    logic       w_tick;
    logic       w_last;

    assign w_tick = (r_div == 8'(SPI_DIV - 1));
    assign w_last = w_tick && (r_phase == 4'd15);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SPI_IDLE: if (start) w_state_next = SPI_XFER;
            SPI_XFER: if (w_last) w_state_next = SPI_IDLE;
            default:  w_state_next = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= SPI_IDLE;
        else          r_state <= w_state_next;
    end

    // Even phases end on a rising SCK (sample MISO), odd phases on a falling
    // SCK (present the next MOSI bit, or finish after the sixteenth phase).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div      <= 8'd0;
            r_phase    <= 4'd0;
            r_tx       <= 8'hFF;
            r_rx_shift <= 8'h00;
            r_rx       <= 8'h00;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b1;
        end else if (r_state == SPI_IDLE) begin
            if (start) begin
                r_tx    <= tx_byte;
                r_mosi  <= tx_byte[7];
                r_div   <= 8'd0;
                r_phase <= 4'd0;
                r_sck   <= 1'b0;
            end
        end else if (w_tick) begin
            r_div   <= 8'd0;
            r_phase <= r_phase + 4'd1;
            if (!r_phase[0]) begin
                r_sck      <= 1'b1;
                r_rx_shift <= {r_rx_shift[6:0], miso};
            end else begin
                r_sck <= 1'b0;
                if (r_phase == 4'd15) begin
                    r_rx   <= r_rx_shift;
                    r_mosi <= 1'b1;
                end else begin
                    r_tx   <= {r_tx[6:0], 1'b1};
                    r_mosi <= r_tx[6];
                end
            end
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

    assign busy    = (r_state == SPI_XFER);
    assign sck     = r_sck;
    assign mosi    = r_mosi;
    assign rx_byte = r_rx;

endmodule

// File: rtl/divmmc_ng.sv
// divMMC-NG: Z80 I/O register file, SD card SPI port and ROM automapper
// that pages the divMMC memory in on trap-address opcode fetches.
module divmmc_ng
    import divmmc_pkg::*;
#(
    parameter int NUM_CARDS  = 2,
    parameter int PAGE_W     = 4,
    parameter int SPI_DIV    = 2,
    parameter int AUTOMAP_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [15:0]          a,
    input  logic                 wr_n,
    input  logic                 rd_n,
    input  logic                 mreq_n,
    input  logic                 m1_n,
    input  logic [7:0]           din,
    output logic [7:0]           dout,
    output logic                 paged_in,
    output logic [PAGE_W-1:0]    sram_page,
    output logic                 mapram,
    output logic                 conmem,
    output logic [NUM_CARDS-1:0] sd_cs_n,
    output logic                 sd_sck,
    output logic                 sd_mosi,
    input  logic                 sd_miso,
    output logic                 spi_busy
);

    logic [7:0]           r_ctrl;
    logic [NUM_CARDS-1:0] r_cs_n;
    logic [7:0]           r_dout;
    logic                 r_trap;
    logic                 r_paged;

    logic       w_io_wr;
    logic       w_io_rd;
    logic       w_spi_start;
    logic       w_busy;
    logic       w_fetch;
    logic [7:0] w_tx;
    logic [7:0] w_rx;
    logic [7:0] w_status;
    logic [7:0] w_rd_data;

    assign w_io_wr     = enable && !wr_n;
    assign w_io_rd     = enable && !rd_n;
    assign w_spi_start = !w_busy && (a[3:0] == PORT_DATA) && (w_io_wr || w_io_rd);
    assign w_tx        = w_io_wr ? din : 8'hFF;
    assign w_fetch     = (AUTOMAP_EN != 0) && !mreq_n && !rd_n && !m1_n;

    divmmc_spi_engine #(
        .SPI_DIV (SPI_DIV)
    ) u_spi (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_spi_start),
        .tx_byte (w_tx),
        .rx_byte (w_rx),
        .busy    (w_busy),
        .sck     (sd_sck),
        .mosi    (sd_mosi),
        .miso    (sd_miso)
    );

    always_comb begin
        w_status = 8'h00;
        w_status[STATUS_BUSY_BIT] = w_busy;
        w_rd_data = 8'hFF;
        case (a[3:0])
            PORT_CTRL:   w_rd_data = r_ctrl;
            PORT_CARD:   w_rd_data = 8'(r_cs_n);
            PORT_DATA:   w_rd_data = w_rx;
            PORT_STATUS: w_rd_data = w_status;
            default:     w_rd_data = 8'hFF;
        endcase
    end

    // MAPRAM (ctrl bit 6) can only be set by software; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl <= 8'h00;
            r_cs_n <= '1;
            r_dout <= 8'h00;
        end else begin
            if (w_io_wr && (a[3:0] == PORT_CTRL))
                r_ctrl <= {din[7], r_ctrl[6] | din[6], din[5:0]};
            if (w_io_wr && (a[3:0] == PORT_CARD))
                r_cs_n <= din[NUM_CARDS-1:0];
            if (w_io_rd)
                r_dout <= w_rd_data;
        end
    end

    // ROM-area traps page in immediately; other traps only take effect once
    // M1 ends, when paged_in follows the armed state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trap  <= 1'b0;
            r_paged <= 1'b0;
        end else if (w_fetch) begin
            if (is_rom_trap(a)) begin
                r_trap  <= 1'b1;
                r_paged <= 1'b1;
            end else if (is_entry_trap(a)) begin
                r_trap <= 1'b1;
            end else if (is_exit_trap(a)) begin
                r_trap <= 1'b0;
            end
        end else if (m1_n) begin
            r_paged <= r_trap;
        end
    end

    assign dout      = r_dout;
    assign paged_in  = r_paged;
    assign sram_page = r_ctrl[PAGE_W-1:0];
    assign mapram    = r_ctrl[6];
    assign conmem    = r_ctrl[7];
    assign sd_cs_n   = r_cs_n;
    assign spi_busy  = w_busy;

endmodule
